// File: rtl/reg_dep_scoreboard.sv
// reg_dep_scoreboard: register dependency scoreboard for the 8 x86 GPRs.
// Sits between decode and issue. Each register keeps a count of in-flight
// writers. A decoded source whose register has a pending write is reported
// busy and raises stall.
//
// Ports:
//   clk, rst_n           rising-edge clock, synchronous active-low reset
//   flush                clears every pending count (beats alloc/release)
//   alloc_v/alloc_reg    issue allocates a destination-register write
//   release_v/_reg       writeback retires a register write
//   src1_v/_reg          source operand 1 lookup
//   src2_v/_reg          source operand 2 lookup
//   src1_busy/src2_busy  combinational busy lookups from current counts
//   alloc_ready          alloc_reg can accept one more writer this cycle
//   stall                source dependency or blocked alloc
//   busy_mask            registered view, bit r = (cnt[r] != 0)
//   err                  sticky: alloc overflow or release underflow seen
//
// Build option: SCOREBOARD_BYPASS_EN
//   When defined, a source whose register is released this cycle with a
//   count of 1 reads as not busy (writeback-to-read bypass).

// 3-bit register-ID equality compare.
module equalitycheck3 (
  input  logic [2:0] a,
  input  logic [2:0] b,
  output logic       eq
);
  assign eq = (a == b);
endmodule

// One tracked register: pending-writer counter plus its ID matches.
module reg_dep_entry #(
  parameter int         CNT_W = 2,
  parameter logic [2:0] ID    = 3'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       alloc_v,
  input  logic [2:0] alloc_reg,
  input  logic       alloc_ok,
  input  logic       release_v,
  input  logic [2:0] release_reg,
  input  logic [2:0] src1_reg,
  input  logic [2:0] src2_reg,
  output logic       cnt_nz,
  output logic       alloc_blk,
  output logic       rel_under,
  output logic       src1_hit,
  output logic       src2_hit
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic a_m, r_m, s1_m, s2_m;
  logic rel_hit, inc, dec, look_busy;

  equalitycheck3 u_eq_a  (.a(alloc_reg),   .b(ID), .eq(a_m));
  equalitycheck3 u_eq_r  (.a(release_reg), .b(ID), .eq(r_m));
  equalitycheck3 u_eq_s1 (.a(src1_reg),    .b(ID), .eq(s1_m));
  equalitycheck3 u_eq_s2 (.a(src2_reg),    .b(ID), .eq(s2_m));

  always_comb begin
    rel_hit   = release_v & r_m;
    cnt_nz    = (cnt_q != '0);
    // Full counter blocks a new writer unless one retires in the same cycle.
    alloc_blk = a_m & (&cnt_q) & ~rel_hit;
    rel_under = rel_hit & ~cnt_nz;
    inc       = alloc_v & alloc_ok & a_m & ~flush;
    dec       = rel_hit & cnt_nz;
`ifdef SCOREBOARD_BYPASS_EN
    // Last writer retiring now: its result is forwarded, so no stall.
    look_busy = cnt_nz & ~(rel_hit & (cnt_q == CNT_W'(1)));
`else
    look_busy = cnt_nz;
`endif
    src1_hit  = s1_m & look_busy;
    src2_hit  = s2_m & look_busy;
    if (flush) cnt_d = '0;
    else       cnt_d = cnt_q + CNT_W'(inc) - CNT_W'(dec);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

module reg_dep_scoreboard #(
  parameter int NREG  = 8,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            alloc_v,
  input  logic [2:0]      alloc_reg,
  input  logic            release_v,
  input  logic [2:0]      release_reg,
  input  logic            src1_v,
  input  logic [2:0]      src1_reg,
  input  logic            src2_v,
  input  logic [2:0]      src2_reg,
  output logic            src1_busy,
  output logic            src2_busy,
  output logic            alloc_ready,
  output logic            stall,
  output logic [NREG-1:0] busy_mask,
  output logic            err
);
  logic [NREG-1:0] cnt_nz, alloc_blk, rel_under, src1_hit, src2_hit;
  logic alloc_ok;
  logic err_q, err_d;

  for (genvar r = 0; r < NREG; r++) begin : g_reg
    reg_dep_entry #(.CNT_W(CNT_W), .ID(3'(r))) u_ent (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .alloc_v(alloc_v), .alloc_reg(alloc_reg), .alloc_ok(alloc_ok),
      .release_v(release_v), .release_reg(release_reg),
      .src1_reg(src1_reg), .src2_reg(src2_reg),
      .cnt_nz(cnt_nz[r]), .alloc_blk(alloc_blk[r]), .rel_under(rel_under[r]),
      .src1_hit(src1_hit[r]), .src2_hit(src2_hit[r])
    );
  end

  always_comb begin
    alloc_ok    = ~|alloc_blk;
    alloc_ready = alloc_ok;
    src1_busy   = |src1_hit;
    src2_busy   = |src2_hit;
    stall       = (src1_v & src1_busy) | (src2_v & src2_busy) | (alloc_v & ~alloc_ok);
    busy_mask   = cnt_nz;
    // A flush discards the cycle's alloc/release, so it cannot raise err.
    err_d       = err_q | (~flush & ((alloc_v & ~alloc_ok) | (|rel_under)));
    err         = err_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
endmodule

// File: tb/tb_reg_dep_scoreboard.sv
module tb_reg_dep_scoreboard;
`ifdef SCOREBOARD_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, flush, alloc_v, release_v, src1_v, src2_v;
  logic [2:0] alloc_reg, release_reg, src1_reg, src2_reg;
  logic src1_busy, src2_busy, alloc_ready, stall, err;
  logic [7:0] busy_mask;

  always #5 clk = ~clk;

  reg_dep_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alloc_v(alloc_v), .alloc_reg(alloc_reg),
    .release_v(release_v), .release_reg(release_reg),
    .src1_v(src1_v), .src1_reg(src1_reg),
    .src2_v(src2_v), .src2_reg(src2_reg),
    .src1_busy(src1_busy), .src2_busy(src2_busy),
    .alloc_ready(alloc_ready), .stall(stall),
    .busy_mask(busy_mask), .err(err)
  );

  typedef struct {
    string      name;
    logic       rst, fl, av, rv, s1v, s2v;
    logic [2:0] ar, rr, s1r, s2r;
    logic       e_s1b, e_s2b, e_ar, e_st, e_err;
    logic [7:0] e_bm;
  } vec_t;

  vec_t tbl[$];
  int n_chk = 0;
  int n_pass = 0;

  function automatic vec_t mk(string name, logic rst, logic fl,
      logic av, logic [2:0] ar, logic rv, logic [2:0] rr,
      logic s1v, logic [2:0] s1r, logic s2v, logic [2:0] s2r,
      logic e_s1b, logic e_s2b, logic e_ar, logic e_st,
      logic [7:0] e_bm, logic e_err);
    vec_t v;
    v.name = name; v.rst = rst; v.fl = fl;
    v.av = av; v.ar = ar; v.rv = rv; v.rr = rr;
    v.s1v = s1v; v.s1r = s1r; v.s2v = s2v; v.s2r = s2r;
    v.e_s1b = e_s1b; v.e_s2b = e_s2b; v.e_ar = e_ar; v.e_st = e_st;
    v.e_bm = e_bm; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(string name, string fld, logic [7:0] act, logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s.%s got %0h want %0h", name, fld, act, exp);
  endtask

  task automatic drive(input vec_t v);
    rst_n = ~v.rst; flush = v.fl;
    alloc_v = v.av; alloc_reg = v.ar;
    release_v = v.rv; release_reg = v.rr;
    src1_v = v.s1v; src1_reg = v.s1r;
    src2_v = v.s2v; src2_reg = v.s2r;
  endtask

  task automatic check_all(input vec_t v);
    chk(v.name, "src1_busy",   {7'd0, src1_busy},   {7'd0, v.e_s1b});
    chk(v.name, "src2_busy",   {7'd0, src2_busy},   {7'd0, v.e_s2b});
    chk(v.name, "alloc_ready", {7'd0, alloc_ready}, {7'd0, v.e_ar});
    chk(v.name, "stall",       {7'd0, stall},       {7'd0, v.e_st});
    chk(v.name, "busy_mask",   busy_mask,           v.e_bm);
    chk(v.name, "err",         {7'd0, err},         {7'd0, v.e_err});
  endtask

  initial begin
    vec_t v;
    // name rst fl av ar rv rr s1v s1r s2v s2r | s1b s2b ar st bm err
    tbl.push_back(mk("rst0",     1,0, 0,0, 0,0, 0,0, 0,0,  0,0,1,0,8'h00,0));
    tbl.push_back(mk("idle",     0,0, 0,0, 0,0, 0,0, 0,0,  0,0,1,0,8'h00,0));
    tbl.push_back(mk("alloc3",   0,0, 1,3, 0,0, 0,0, 0,0,  0,0,1,0,8'h00,0));
    tbl.push_back(mk("look3",    0,0, 0,0, 0,0, 1,3, 0,0,  1,0,1,1,8'h08,0));
    tbl.push_back(mk("rel3look", 0,0, 0,0, 1,3, 1,3, 0,0,  ~BYP,0,1,~BYP,8'h08,0));
    tbl.push_back(mk("look3clr", 0,0, 0,0, 0,0, 1,3, 0,0,  0,0,1,0,8'h00,0));
    tbl.push_back(mk("a5_1",     0,0, 1,5, 0,0, 0,0, 0,0,  0,0,1,0,8'h00,0));
    tbl.push_back(mk("a5_2",     0,0, 1,5, 0,0, 0,0, 0,0,  0,0,1,0,8'h20,0));
    tbl.push_back(mk("a5_3",     0,0, 1,5, 0,0, 0,0, 0,0,  0,0,1,0,8'h20,0));
    tbl.push_back(mk("a5_ovf",   0,0, 1,5, 0,0, 0,0, 0,0,  0,0,0,1,8'h20,0));
    tbl.push_back(mk("a5r5",     0,0, 1,5, 1,5, 0,0, 0,0,  0,0,1,0,8'h20,1));
    tbl.push_back(mk("a5full",   0,0, 1,5, 0,0, 0,0, 0,0,  0,0,0,1,8'h20,1));
    tbl.push_back(mk("r5_1",     0,0, 0,0, 1,5, 0,0, 0,0,  0,0,1,0,8'h20,1));
    tbl.push_back(mk("r5_2",     0,0, 0,0, 1,5, 0,0, 0,0,  0,0,1,0,8'h20,1));
    tbl.push_back(mk("r5_3",     0,0, 0,0, 1,5, 0,0, 0,0,  0,0,1,0,8'h20,1));
    tbl.push_back(mk("r5empty",  0,0, 0,0, 0,0, 0,0, 0,0,  0,0,1,0,8'h00,1));
    tbl.push_back(mk("rst1",     1,0, 0,0, 0,0, 0,0, 0,0,  0,0,1,0,8'h00,0));
    tbl.push_back(mk("rel2unf",  0,0, 0,0, 1,2, 0,0, 0,0,  0,0,1,0,8'h00,0));
    tbl.push_back(mk("unf_err",  0,0, 0,0, 0,0, 0,0, 0,0,  0,0,1,0,8'h00,1));
    tbl.push_back(mk("a0",       0,0, 1,0, 0,0, 0,0, 0,0,  0,0,1,0,8'h00,1));
    tbl.push_back(mk("a1",       0,0, 1,1, 0,0, 0,0, 0,0,  1,1,1,0,8'h01,1));
    tbl.push_back(mk("a7",       0,0, 1,7, 0,0, 0,0, 0,0,  1,1,1,0,8'h03,1));
    tbl.push_back(mk("flush_a4", 0,1, 1,4, 0,0, 0,0, 0,0,  1,1,1,0,8'h83,1));
    tbl.push_back(mk("postfl",   0,0, 0,0, 0,0, 1,4, 1,7,  0,0,1,0,8'h00,1));
    tbl.push_back(mk("rst2",     1,0, 0,0, 0,0, 0,0, 0,0,  0,0,1,0,8'h00,0));
    tbl.push_back(mk("a6",       0,0, 1,6, 0,0, 0,0, 0,0,  0,0,1,0,8'h00,0));
    tbl.push_back(mk("r6byp",    0,0, 0,0, 1,6, 0,0, 1,6,  0,~BYP,1,~BYP,8'h40,0));
    tbl.push_back(mk("r6after",  0,0, 0,0, 0,0, 0,0, 1,6,  0,0,1,0,8'h00,0));
    tbl.push_back(mk("a6_1",     0,0, 1,6, 0,0, 0,0, 0,0,  0,0,1,0,8'h00,0));
    tbl.push_back(mk("a6_2",     0,0, 1,6, 0,0, 0,0, 0,0,  0,0,1,0,8'h40,0));
    tbl.push_back(mk("r6cnt2",   0,0, 0,0, 1,6, 0,0, 1,6,  0,1,1,1,8'h40,0));
    tbl.push_back(mk("r6cnt1",   0,0, 0,0, 0,0, 0,0, 1,6,  0,1,1,1,8'h40,0));
    tbl.push_back(mk("r6last",   0,0, 0,0, 1,6, 0,0, 0,0,  0,0,1,0,8'h40,0));
    tbl.push_back(mk("r6done",   0,0, 0,0, 0,0, 0,0, 1,6,  0,0,1,0,8'h00,0));

    v = mk("idle_in", 1,0, 0,0, 0,0, 0,0, 0,0, 0,0,1,0,8'h00,0);
    drive(v);

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      if (!tbl[i].rst) check_all(tbl[i]);
    end

    // Flush together with an overflowing alloc must not raise err.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(mk("a2", 0,0, 1,2, 0,0, 0,0, 0,0, 0,0,0,0,8'h00,0));
    end
    @(negedge clk);
    drive(mk("fl_ovf", 0,1, 1,2, 0,0, 0,0, 0,0, 0,0,0,0,8'h00,0));
    #1;
    chk("fl_ovf", "alloc_ready", {7'd0, alloc_ready}, 8'd0);
    chk("fl_ovf", "busy_mask",   busy_mask,           8'h04);
    @(negedge clk);
    drive(mk("idle", 0,0, 0,0, 0,0, 0,0, 0,0, 0,0,0,0,8'h00,0));
    #1;
    chk("fl_ovf_after", "err",       {7'd0, err}, 8'd0);
    chk("fl_ovf_after", "busy_mask", busy_mask,   8'h00);

    // Reset in the middle of activity drops all counts and err.
    @(negedge clk);
    drive(mk("a1", 0,0, 1,1, 1,3, 0,0, 0,0, 0,0,0,0,8'h00,0));
    @(negedge clk);
    drive(mk("a1", 0,0, 1,1, 0,0, 0,0, 0,0, 0,0,0,0,8'h00,0));
    #1;
    chk("midrst_pre", "busy_mask", busy_mask,   8'h02);
    chk("midrst_pre", "err",       {7'd0, err}, 8'd1);
    @(negedge clk);
    drive(mk("rst", 1,0, 1,1, 0,0, 0,0, 0,0, 0,0,0,0,8'h00,0));
    @(negedge clk);
    drive(mk("idle", 0,0, 0,0, 0,0, 1,1, 0,0, 0,0,0,0,8'h00,0));
    #1;
    chk("midrst_post", "busy_mask", busy_mask,   8'h00);
    chk("midrst_post", "err",       {7'd0, err}, 8'd0);
    chk("midrst_post", "stall",     {7'd0, stall}, 8'd0);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
